// File: rtl/vga_scan_driver.sv
// rtl/vga_scan_driver.sv - 640x480@60 VGA raster timing, pixel request bus and pin register
module vga_scan_driver #(
    parameter int H_SYNC  = 96,
    parameter int H_BACK  = 48,
    parameter int H_DISP  = 640,
    parameter int H_FRONT = 16,
    parameter int V_SYNC  = 2,
    parameter int V_BACK  = 33,
    parameter int V_DISP  = 480,
    parameter int V_FRONT = 10
) (
    input  logic        vga_clk,
    input  logic        sys_rst_n,
    input  logic [23:0] pixel_data,
    output logic [9:0]  pixel_xpos,
    output logic [9:0]  pixel_ypos,
    output logic        pixel_req,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_de,
    output logic [23:0] vga_rgb,
    output logic        frame_tick
);
    localparam logic [9:0] H_LAST     = 10'(H_SYNC + H_BACK + H_DISP + H_FRONT - 1);
    localparam logic [9:0] V_LAST     = 10'(V_SYNC + V_BACK + V_DISP + V_FRONT - 1);
    localparam logic [9:0] H_SYNC_END = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_END = 10'(V_SYNC);
    localparam logic [9:0] H_ACT_BEG  = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] H_ACT_END  = 10'(H_SYNC + H_BACK + H_DISP);
    localparam logic [9:0] V_ACT_BEG  = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] V_ACT_END  = 10'(V_SYNC + V_BACK + V_DISP);
    // Requests lead the active region by one clock to cover the renderer's register.
    localparam logic [9:0] H_REQ_BEG  = 10'(H_SYNC + H_BACK - 1);
    localparam logic [9:0] H_REQ_END  = 10'(H_SYNC + H_BACK + H_DISP - 1);

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       h_wrap;
    logic       v_act;
    logic       active;

    assign h_wrap = (h_cnt == H_LAST);

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_wrap) begin
            h_cnt <= '0;
            if (v_cnt == V_LAST) begin
                v_cnt <= '0;
            end else begin
                v_cnt <= v_cnt + 10'd1;
            end
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    assign v_act      = (v_cnt >= V_ACT_BEG) && (v_cnt < V_ACT_END);
    assign active     = v_act && (h_cnt >= H_ACT_BEG) && (h_cnt < H_ACT_END);
    assign pixel_req  = v_act && (h_cnt >= H_REQ_BEG) && (h_cnt < H_REQ_END);
    assign pixel_xpos = pixel_req ? (h_cnt - H_REQ_BEG) : '0;
    assign pixel_ypos = pixel_req ? (v_cnt - V_ACT_BEG) : '0;

    // All pin outputs share this one stage so sync, enable and colour stay aligned.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vga_hs     <= 1'b1;
            vga_vs     <= 1'b1;
            vga_de     <= 1'b0;
            vga_rgb    <= '0;
            frame_tick <= 1'b0;
        end else begin
            vga_hs     <= ~(h_cnt < H_SYNC_END);
            vga_vs     <= ~(v_cnt < V_SYNC_END);
            vga_de     <= active;
            vga_rgb    <= active ? pixel_data : '0;
            frame_tick <= (h_cnt == '0) && (v_cnt == '0);
        end
    end
endmodule

// File: tb/tb_vga_scan_driver.sv
// tb/tb_vga_scan_driver.sv - bench for vga_scan_driver: full-size and shrunk-timing instances against a closed-form raster model
module tb_vga_scan_driver;
    typedef struct {
        int hs, hb, hd, hf, vs, vb, vd, vf;
    } tim_t;

    tim_t ta = '{96, 48, 640, 16, 2, 33, 480, 10};
    tim_t tb = '{4, 3, 10, 2, 2, 3, 6, 2};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b, const_b, run_cmp, meas_b;
    logic [23:0] pd_a, pd_b, stub_a, stub_b, rgb_a, rgb_b;
    logic [9:0]  x_a, y_a, x_b, y_b;
    logic        req_a, hs_a, vs_a, de_a, ft_a;
    logic        req_b, hs_b, vs_b, de_b, ft_b;
    int          e_a = 0, e_b = 0;
    int          n_cmp = 0, n_bad = 0;

    vga_scan_driver dut_a (
        .vga_clk(clk), .sys_rst_n(rst_a), .pixel_data(pd_a),
        .pixel_xpos(x_a), .pixel_ypos(y_a), .pixel_req(req_a),
        .vga_hs(hs_a), .vga_vs(vs_a), .vga_de(de_a), .vga_rgb(rgb_a), .frame_tick(ft_a)
    );

    vga_scan_driver #(
        .H_SYNC(4), .H_BACK(3), .H_DISP(10), .H_FRONT(2),
        .V_SYNC(2), .V_BACK(3), .V_DISP(6), .V_FRONT(2)
    ) dut_b (
        .vga_clk(clk), .sys_rst_n(rst_b), .pixel_data(pd_b),
        .pixel_xpos(x_b), .pixel_ypos(y_b), .pixel_req(req_b),
        .vga_hs(hs_b), .vga_vs(vs_b), .vga_de(de_b), .vga_rgb(rgb_b), .frame_tick(ft_b)
    );

    // Stub renderers: register the requested coordinate as the colour.
    always @(posedge clk or negedge rst_a)
        if (!rst_a) stub_a <= '0; else stub_a <= {4'h0, x_a, y_a};
    always @(posedge clk or negedge rst_b)
        if (!rst_b) stub_b <= '0; else stub_b <= {4'h0, x_b, y_b};
    assign pd_a = stub_a;
    assign pd_b = const_b ? 24'hFFFFFF : stub_b;

    always @(posedge clk or negedge rst_a)
        if (!rst_a) e_a <= 0; else e_a <= e_a + 1;
    always @(posedge clk or negedge rst_b)
        if (!rst_b) e_b <= 0; else e_b <= e_b + 1;

    function automatic int htot(tim_t p); return p.hs + p.hb + p.hd + p.hf; endfunction
    function automatic int vtot(tim_t p); return p.vs + p.vb + p.vd + p.vf; endfunction
    function automatic int hpos(tim_t p, int t); return t % htot(p); endfunction
    function automatic int vpos(tim_t p, int t); return (t / htot(p)) % vtot(p); endfunction
    function automatic bit row_vis(tim_t p, int t);
        return vpos(p, t) >= p.vs + p.vb && vpos(p, t) < p.vs + p.vb + p.vd;
    endfunction
    function automatic bit is_active(tim_t p, int t);
        return row_vis(p, t) && hpos(p, t) >= p.hs + p.hb && hpos(p, t) < p.hs + p.hb + p.hd;
    endfunction
    function automatic bit is_req(tim_t p, int t);
        return is_active(p, t + 1) && hpos(p, t) != htot(p) - 1;
    endfunction
    function automatic int col(tim_t p, int t); return hpos(p, t) - (p.hs + p.hb - 1); endfunction
    function automatic int row(tim_t p, int t); return vpos(p, t) - (p.vs + p.vb); endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // e = edges since release; counters hold state e, pins show state e-1.
    task automatic check(input string tag, input tim_t p, input int e, input bit cm,
                         input logic [9:0] x, input logic [9:0] y, input logic req,
                         input logic hs, input logic vs, input logic de, input logic ft,
                         input logic [23:0] rgb);
        bit          rq;
        int          s;
        logic [23:0] rgb_e;
        string       sfx;
        sfx = $sformatf("%s e=%0d", tag, e);
        rq = is_req(p, e);
        cmp({sfx, " req"}, req, rq);
        cmp({sfx, " xpos"}, x, rq ? col(p, e) : 0);
        cmp({sfx, " ypos"}, y, rq ? row(p, e) : 0);
        if (e == 0) begin
            cmp({sfx, " hs"}, hs, 1);
            cmp({sfx, " vs"}, vs, 1);
            cmp({sfx, " de"}, de, 0);
            cmp({sfx, " ft"}, ft, 0);
            cmp({sfx, " rgb"}, rgb, 0);
        end else begin
            s = e - 1;
            rgb_e = '0;
            if (is_active(p, s))
                rgb_e = cm ? 24'hFFFFFF :
                        (e >= 2 && is_req(p, e - 2)) ? {4'h0, 10'(col(p, e - 2)), 10'(row(p, e - 2))} : 24'h0;
            cmp({sfx, " hs"}, hs, hpos(p, s) >= p.hs);
            cmp({sfx, " vs"}, vs, vpos(p, s) >= p.vs);
            cmp({sfx, " de"}, de, is_active(p, s));
            cmp({sfx, " ft"}, ft, hpos(p, s) == 0 && vpos(p, s) == 0);
            cmp({sfx, " rgb"}, rgb, rgb_e);
        end
    endtask

    always @(negedge clk) begin
        if (run_cmp) begin
            check("A", ta, e_a, 1'b0, x_a, y_a, req_a, hs_a, vs_a, de_a, ft_a, rgb_a);
            check("B", tb, e_b, const_b, x_b, y_b, req_b, hs_b, vs_b, de_b, ft_b, rgb_b);
        end
    end

    // Full-size instance: hand-computed landmarks of the first frame.
    int hs_lo = 0, hs_hi = 0, vs_lo = 0, de_line = 0, ft_cnt_a = 0;
    int first_req_e = -1, first_de_e = -1;
    logic [23:0] first_de_rgb = 24'hx;
    always @(negedge clk) begin
        if (run_cmp && rst_a && e_a > 0) begin
            if (e_a <= 800) begin
                if (hs_a) hs_hi++; else hs_lo++;
            end
            if (e_a <= 2000 && !vs_a) vs_lo++;
            if (e_a > 28000 && e_a <= 28800 && de_a) de_line++;
            if (ft_a) ft_cnt_a++;
            if (req_a && first_req_e < 0) first_req_e = e_a;
            if (de_a && first_de_e < 0) begin
                first_de_e = e_a;
                first_de_rgb = rgb_a;
            end
            if (e_a == 800) begin
                cmp("A hs low clocks first line", hs_lo, 96);
                cmp("A hs high clocks first line", hs_hi, 704);
            end
            if (e_a == 2000) cmp("A vs low clocks", vs_lo, 1600);
            if (e_a == 28800) cmp("A de clocks line 35", de_line, 640);
            if (e_a == 28142) cmp("A req before window", req_a, 0);
            if (e_a == 28143) cmp("A first request", {req_a, x_a, y_a}, {1'b1, 10'd0, 10'd0});
            if (e_a == 28782) cmp("A last column request", {req_a, x_a, y_a}, {1'b1, 10'd639, 10'd0});
            if (e_a == 28783) cmp("A request at h783", {req_a, x_a, y_a}, 21'd0);
        end
    end

    // Shrunk instance: structural measurements over many frames.
    int de_run, lines, hs_run, vs_run, last_ft_e, max_x, max_y;
    bit seen_ft, first_pending, prev_de;
    logic [23:0] last_rgb;
    always @(negedge clk) begin
        if (!meas_b) begin
            de_run = 0; lines = 0; hs_run = 0; vs_run = 0; last_ft_e = 0;
            max_x = 0; max_y = 0; seen_ft = 0; first_pending = 0; prev_de = 0; last_rgb = '0;
        end else if (rst_b) begin
            if (de_b) begin
                de_run++;
                if (!prev_de) lines++;
                if (first_pending) begin
                    cmp("B first de rgb of frame", rgb_b, 24'h0);
                    first_pending = 0;
                end
                last_rgb = rgb_b;
            end else if (prev_de) begin
                cmp("B de run length", de_run, 10);
                de_run = 0;
            end
            if (!hs_b) hs_run++;
            else if (hs_run != 0) begin
                cmp("B hs low run", hs_run, 4);
                hs_run = 0;
            end
            if (!vs_b) vs_run++;
            else if (vs_run != 0) begin
                cmp("B vs low run", vs_run, 38);
                vs_run = 0;
            end
            if (ft_b) begin
                if (seen_ft) begin
                    cmp("B frame tick spacing", e_b - last_ft_e, 247);
                    cmp("B de lines per frame", lines, 6);
                    cmp("B last de rgb of frame", last_rgb, {4'h0, 10'd9, 10'd5});
                end
                seen_ft = 1;
                last_ft_e = e_b;
                lines = 0;
                first_pending = 1;
            end
            if (req_b && int'(x_b) > max_x) max_x = int'(x_b);
            if (req_b && int'(y_b) > max_y) max_y = int'(y_b);
            prev_de = de_b;
        end
    end

    initial begin
        rst_a = 1'b0; rst_b = 1'b0; const_b = 1'b1; run_cmp = 1'b0; meas_b = 1'b0;
        repeat (3) @(negedge clk);
        cmp("B reset outputs", {hs_b, vs_b, de_b, ft_b, req_b}, 5'b11000);
        cmp("B reset rgb", rgb_b, 24'h0);
        cmp("B reset coords", {x_b, y_b}, 20'h0);
        cmp("A reset outputs", {hs_a, vs_a, de_a, ft_a, req_a}, 5'b11000);
        run_cmp = 1'b1;
        #1 rst_a = 1'b1; rst_b = 1'b1;
        // Constant-white phase, then a reset pulse at v=8, h=10 mid active line.
        repeat (19 * 8 + 10) @(negedge clk);
        cmp("B de before pulse", {de_b, rgb_b}, {1'b1, 24'hFFFFFF});
        #1 rst_b = 1'b0;
        #1;
        cmp("B pulse clears sync/de/tick", {hs_b, vs_b, de_b, ft_b, req_b}, 5'b11000);
        cmp("B pulse clears rgb", rgb_b, 24'h0);
        cmp("B pulse clears coords", {x_b, y_b}, 20'h0);
        const_b = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_b = 1'b1; meas_b = 1'b1;
        @(negedge clk);
        cmp("B frame tick on first edge", ft_b, 1);
        cmp("B hs low on first edge", hs_b, 0);
        while (e_a < 29000) @(negedge clk);
        run_cmp = 1'b0;
        cmp("A frame tick count", ft_cnt_a, 1);
        cmp("A first req edge", first_req_e, 28143);
        cmp("A first de edge", first_de_e, 28145);
        cmp("A first de rgb", first_de_rgb, 24'h0);
        cmp("B max xpos", max_x, 9);
        cmp("B max ypos", max_y, 5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
